// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the CPU bus-cycle controller.
//   target_t - decoded destination of a bus cycle
//   state_t  - bus-cycle FSM state encoding
//   Region nibble constants refer to A[23:20] of the CPU byte address.
package cpu_bus_pkg;

    typedef enum logic [1:0] {T_RAM, T_ROM, T_VPA, T_NONE} target_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_ACK,
        S_VPA,
        S_WAIT_TO,
        S_END
    } state_t;

    localparam logic [3:0] ROM_LO  = 4'h4;   // first ROM region nibble, ROM spans 4..7
    localparam logic [3:0] VIA     = 4'hE;   // VIA / E-clock peripheral region
    localparam logic [2:0] FC_IACK = 3'b111; // interrupt acknowledge function code

    // True for the four-nibble ROM window starting at ROM_LO.
    function automatic logic in_rom(input logic [3:0] region);
        return (region >= ROM_LO) && (region <= ROM_LO + 4'd3);
    endfunction

endpackage

// File: rtl/cpu_addr_decode.sv
// cpu_addr_decode: combinational bus-target decode.
//   region  in  4  A[23:20] of the CPU byte address
//   fc      in  3  CPU function code
//   overlay in  1  boot overlay: ROM mirrored into the low RAM window
//   target  out    decoded target (T_RAM / T_ROM / T_VPA / T_NONE)
module cpu_addr_decode
    import cpu_bus_pkg::*;
(
    input  logic [3:0] region,
    input  logic [2:0] fc,
    input  logic       overlay,
    output target_t    target
);

    always_comb begin
        target = T_NONE;
        // Interrupt acknowledge always autovectors, whatever the address bus says.
        if (fc == FC_IACK)
            target = T_VPA;
        else if (region < ROM_LO)
            target = overlay ? T_ROM : T_RAM;
        else if (in_rom(region))
            target = T_ROM;
        else if (region == VIA)
            target = T_VPA;
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: CPU bus-cycle controller.
// Samples the CPU strobes on cpu_en_p, decodes the target, runs a level
// req / pulse ack handshake with the memory controller and terminates the
// CPU cycle with _cpuDTACK (memory / timeout) or _cpuVPA (VIA / IACK).
// Ports:
//   clk, _cpuReset            clock, async active-low reset
//   cpu_en_p                  CPU phi1 enable, qualifies all bus sampling
//   _cpuAS/_cpuUDS/_cpuLDS    CPU strobes (active low)
//   _cpuRW, cpuFC, cpuAddr    cycle direction, function code, A[23:1]
//   cpuDataOut / cpuDataIn    CPU write data / registered read data
//   overlay                   boot ROM overlay at address 0
//   _cpuDTACK, _cpuVPA        cycle termination to CPU (registered)
//   mem_req..mem_wdata        request fields to memory, latched at decode
//   mem_ack, mem_rdata        completion pulse and read data from memory
//   bus_timeout               one-clock pulse on unmapped-cycle timeout
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [15:0] OPEN_BUS = 16'hFFFF
) (
    input  logic        clk,
    input  logic        _cpuReset,
    input  logic        cpu_en_p,
    input  logic        _cpuAS,
    input  logic        _cpuUDS,
    input  logic        _cpuLDS,
    input  logic        _cpuRW,
    input  logic [2:0]  cpuFC,
    input  logic [22:0] cpuAddr,
    input  logic [15:0] cpuDataOut,
    input  logic        overlay,
    output logic        _cpuDTACK,
    output logic        _cpuVPA,
    output logic [15:0] cpuDataIn,
    output logic        mem_req,
    output logic        mem_rom,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        bus_timeout
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    target_t    target;
    logic [7:0] to_cnt;
    logic       aborted;   // AS went away while memory was still busy

    logic is_iack;
    logic cycle_start;
    logic as_high;

    cpu_addr_decode u_dec (
        .region  (cpuAddr[22:19]),
        .fc      (cpuFC),
        .overlay (overlay),
        .target  (target)
    );

    assign is_iack     = (cpuFC == FC_IACK);
    // IACK cycles may run with both data strobes inactive.
    assign cycle_start = cpu_en_p && !_cpuAS && (is_iack || !_cpuUDS || !_cpuLDS);
    assign as_high     = cpu_en_p && _cpuAS;

    always_ff @(posedge clk or negedge _cpuReset) begin
        if (!_cpuReset) begin
            state       <= S_IDLE;
            _cpuDTACK   <= 1'b1;
            _cpuVPA     <= 1'b1;
            cpuDataIn   <= OPEN_BUS;
            mem_req     <= 1'b0;
            mem_rom     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 2'b00;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            bus_timeout <= 1'b0;
            to_cnt      <= '0;
            aborted     <= 1'b0;
        end else begin
            bus_timeout <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cycle_start) begin
                        mem_we    <= ~_cpuRW;
                        mem_be    <= {~_cpuUDS, ~_cpuLDS};
                        mem_addr  <= cpuAddr[21:0];
                        mem_wdata <= cpuDataOut;
                        aborted   <= 1'b0;
                        unique case (target)
                            T_RAM, T_ROM: begin
                                mem_req <= 1'b1;
                                mem_rom <= (target == T_ROM);
                                state   <= S_MEM;
                            end
                            T_VPA: begin
                                _cpuVPA <= 1'b0;
                                state   <= S_VPA;
                            end
                            default: begin
                                to_cnt <= '0;
                                state  <= S_WAIT_TO;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        // The memory controller cannot abort, so an abandoned
                        // cycle still waits for its ack and then drops the data.
                        if (aborted || as_high) begin
                            state <= S_IDLE;
                        end else begin
                            if (!mem_we)
                                cpuDataIn <= mem_rdata;
                            _cpuDTACK <= 1'b0;
                            state     <= S_ACK;
                        end
                    end else if (as_high) begin
                        aborted <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (as_high) begin
                        _cpuDTACK <= 1'b1;
                        state     <= S_END;
                    end
                end
                S_VPA: begin
                    if (as_high) begin
                        _cpuVPA <= 1'b1;
                        state   <= S_END;
                    end
                end
                S_WAIT_TO: begin
                    if (as_high) begin
                        to_cnt <= '0;
                        state  <= S_IDLE;
                    end else if (cpu_en_p) begin
                        if (to_cnt == TO_LAST) begin
                            to_cnt      <= '0;
                            cpuDataIn   <= OPEN_BUS;
                            bus_timeout <= 1'b1;
                            _cpuDTACK   <= 1'b0;
                            state       <= S_ACK;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                end
                S_END: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl: table-driven directed bench for cpu_bus_ctrl, plus
// hand-written sequences for aborted cycles, timeout abandonment, stray
// acks and mid-cycle reset.
module tb_cpu_bus_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk, _cpuReset, cpu_en_p;
    logic        _cpuAS, _cpuUDS, _cpuLDS, _cpuRW;
    logic [2:0]  cpuFC;
    logic [22:0] cpuAddr;
    logic [15:0] cpuDataOut, cpuDataIn;
    logic        overlay, _cpuDTACK, _cpuVPA;
    logic        mem_req, mem_rom, mem_we, mem_ack, bus_timeout;
    logic [1:0]  mem_be;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    cpu_bus_ctrl #(.TIMEOUT(TIMEOUT), .OPEN_BUS(16'hFFFF)) dut (
        .clk(clk), ._cpuReset(_cpuReset), .cpu_en_p(cpu_en_p),
        ._cpuAS(_cpuAS), ._cpuUDS(_cpuUDS), ._cpuLDS(_cpuLDS), ._cpuRW(_cpuRW),
        .cpuFC(cpuFC), .cpuAddr(cpuAddr), .cpuDataOut(cpuDataOut), .overlay(overlay),
        ._cpuDTACK(_cpuDTACK), ._cpuVPA(_cpuVPA), .cpuDataIn(cpuDataIn),
        .mem_req(mem_req), .mem_rom(mem_rom), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .bus_timeout(bus_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // phi1 enable: high on every other rising edge, changes on falling edges
    initial begin
        cpu_en_p = 1'b0;
        forever @(negedge clk) cpu_en_p = ~cpu_en_p;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef enum int {K_MEM, K_VPA, K_TO} kind_e;

    typedef struct {
        logic [23:0] addr;     // CPU byte address
        logic        rw;
        logic        uds;
        logic        lds;
        logic [2:0]  fc;
        logic        ovl;
        logic [15:0] wdata;
        int          ack_dly;  // clocks between mem_req seen and mem_ack
        logic [15:0] rdata;
        kind_e       kind;
        logic        rom;
        logic [1:0]  be;
        logic [21:0] maddr;
        logic [15:0] din;      // cpuDataIn after the cycle
    } vec_t;

    vec_t vecs[10];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input vec_t v);
        @(negedge clk);
        cpuAddr    = v.addr[23:1];
        cpuFC      = v.fc;
        _cpuRW     = v.rw;
        cpuDataOut = v.wdata;
        overlay    = v.ovl;
        _cpuUDS    = v.uds;
        _cpuLDS    = v.lds;
        _cpuAS     = 1'b0;
    endtask

    // Release AS, wait for DTACK and VPA to go high, then let END retire.
    task automatic end_cycle(input string name, inout int pulses);
        logic ok;
        @(negedge clk);
        _cpuAS  = 1'b1;
        _cpuUDS = 1'b1;
        _cpuLDS = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin
            tick();
            if (bus_timeout) pulses++;
            if (_cpuDTACK && _cpuVPA) ok = 1'b1;
        end
        chk({name, "_release"}, ok, 1'b1);
        tick();
        if (bus_timeout) pulses++;
        tick();
        if (bus_timeout) pulses++;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        logic  got, held, en, exp_we, bad;
        int    en_cnt, pulses;
        nm = $sformatf("v%0d", idx);
        exp_we = ~v.rw;
        pulses = 0;
        start_cycle(v);
        case (v.kind)
            K_MEM: begin
                got = 1'b0;
                en_cnt = 0;
                for (int c = 0; c < 12 && !got; c++) begin
                    @(posedge clk);
                    en = cpu_en_p;
                    #1;
                    if (en) en_cnt++;
                    if (mem_req) got = 1'b1;
                end
                chk({nm, "_req_seen"}, got, 1'b1);
                // request must appear right after the first enabled sample
                chk({nm, "_req_latency"}, en_cnt, 1);
                chk({nm, "_mem_rom"}, mem_rom, v.rom);
                chk({nm, "_mem_we"}, mem_we, exp_we);
                chk({nm, "_mem_be"}, mem_be, v.be);
                chk({nm, "_mem_addr"}, mem_addr, v.maddr);
                if (exp_we) chk({nm, "_mem_wdata"}, mem_wdata, v.wdata);
                held = 1'b1;
                for (int c = 0; c < v.ack_dly; c++) begin
                    tick();
                    if (!mem_req || !_cpuDTACK) held = 1'b0;
                end
                chk({nm, "_req_held"}, held, 1'b1);
                @(negedge clk);
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
                tick();
                mem_ack = 1'b0;
                chk({nm, "_dtack_low"}, _cpuDTACK, 1'b0);
                chk({nm, "_req_drop"}, mem_req, 1'b0);
                chk({nm, "_data_in"}, cpuDataIn, v.din);
                end_cycle(nm, pulses);
            end
            K_VPA: begin
                got = 1'b0;
                bad = 1'b0;
                for (int c = 0; c < 8 && !got; c++) begin
                    tick();
                    if (mem_req || !_cpuDTACK) bad = 1'b1;
                    if (!_cpuVPA) got = 1'b1;
                end
                chk({nm, "_vpa_low"}, got, 1'b1);
                for (int c = 0; c < 4; c++) begin
                    tick();
                    if (mem_req || !_cpuDTACK || _cpuVPA) bad = 1'b1;
                end
                end_cycle(nm, pulses);
                chk({nm, "_no_req_no_dtack"}, bad, 1'b0);
                chk({nm, "_data_in"}, cpuDataIn, v.din);
            end
            default: begin
                got = 1'b0;
                en_cnt = 0;
                bad = 1'b0;
                for (int c = 0; c < 400 && !got; c++) begin
                    @(posedge clk);
                    en = cpu_en_p;
                    #1;
                    if (en) en_cnt++;
                    if (bus_timeout) pulses++;
                    if (mem_req) bad = 1'b1;
                    if (!_cpuDTACK) got = 1'b1;
                end
                chk({nm, "_to_dtack"}, got, 1'b1);
                // one decode sample plus TIMEOUT counting samples
                chk({nm, "_to_ticks"}, en_cnt, TIMEOUT + 1);
                chk({nm, "_to_no_req"}, bad, 1'b0);
                chk({nm, "_data_in"}, cpuDataIn, v.din);
                end_cycle(nm, pulses);
                chk({nm, "_to_pulses"}, pulses, 1);
            end
        endcase
    endtask

    initial begin
        logic  ok, bad;
        int    pulses;
        vec_t  v;

        //          addr        rw    uds   lds   fc      ovl   wdata     dly rdata     kind   rom   be     maddr         din
        vecs[0] = '{24'h001000, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0000, 5, 16'h1234, K_MEM, 1'b0, 2'b11, 22'h000800, 16'h1234};
        vecs[1] = '{24'h000000, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 16'h0000, 1, 16'hBEEF, K_MEM, 1'b1, 2'b11, 22'h000000, 16'hBEEF};
        vecs[2] = '{24'h000000, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 16'h0000, 0, 16'h5A5A, K_MEM, 1'b0, 2'b11, 22'h000000, 16'h5A5A};
        vecs[3] = '{24'h400001, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 16'h00AB, 2, 16'hDEAD, K_MEM, 1'b1, 2'b01, 22'h200000, 16'h5A5A};
        vecs[4] = '{24'hEFE1FE, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0000, 0, 16'h0000, K_VPA, 1'b0, 2'b11, 22'h000000, 16'h5A5A};
        vecs[5] = '{24'h00FFFE, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 16'h0000, 0, 16'h0000, K_VPA, 1'b0, 2'b00, 22'h000000, 16'h5A5A};
        vecs[6] = '{24'h900000, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0000, 0, 16'h0000, K_TO,  1'b0, 2'b11, 22'h000000, 16'hFFFF};
        vecs[7] = '{24'h7FFFFE, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0000, 3, 16'h0F0F, K_MEM, 1'b1, 2'b11, 22'h3FFFFF, 16'h0F0F};
        vecs[8] = '{24'h3FFFFE, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 16'hCD00, 2, 16'hBAD0, K_MEM, 1'b0, 2'b10, 22'h1FFFFF, 16'h0F0F};
        vecs[9] = '{24'hF00000, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 16'h0000, 0, 16'h0000, K_TO,  1'b0, 2'b11, 22'h000000, 16'hFFFF};

        _cpuReset = 1'b0;
        _cpuAS = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1; _cpuRW = 1'b1;
        cpuFC = 3'b101; cpuAddr = '0; cpuDataOut = '0; overlay = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;

        repeat (3) tick();
        chk("rst_dtack", _cpuDTACK, 1'b1);
        chk("rst_vpa", _cpuVPA, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_timeout", bus_timeout, 1'b0);
        chk("rst_data_in", cpuDataIn, 16'hFFFF);
        @(negedge clk);
        _cpuReset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Stray ack while idle: no DTACK, read data untouched.
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 16'h4444;
        tick();
        mem_ack = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (!_cpuDTACK || mem_req) bad = 1'b1;
        end
        chk("idle_ack_ignored", bad, 1'b0);
        chk("idle_ack_data", cpuDataIn, 16'hFFFF);

        // AS rises while memory is busy: request held to ack, no DTACK, data dropped.
        v = vecs[0];
        v.addr = 24'h002000;
        start_cycle(v);
        ok = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            tick();
            if (mem_req) ok = 1'b1;
        end
        chk("abort_req_seen", ok, 1'b1);
        @(negedge clk);
        _cpuAS = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!mem_req || !_cpuDTACK) bad = 1'b1;
        end
        chk("abort_req_kept", bad, 1'b0);
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0;
        chk("abort_req_drop", mem_req, 1'b0);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!_cpuDTACK || mem_req) bad = 1'b1;
        end
        chk("abort_no_dtack", bad, 1'b0);
        chk("abort_data_kept", cpuDataIn, 16'hFFFF);

        // AS rises during the timeout wait: no pulse, no DTACK.
        start_cycle(vecs[6]);
        repeat (20) tick();
        @(negedge clk);
        _cpuAS = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 160; c++) begin
            tick();
            if (bus_timeout || !_cpuDTACK) bad = 1'b1;
        end
        chk("to_abandon_quiet", bad, 1'b0);
        // a fresh unmapped cycle must count the full window again
        run_vec(vecs[6], 10);

        // Mid-cycle reset: leave known read data, then reset while in MEM.
        v = vecs[0];
        v.rdata = 16'h7777;
        v.din   = 16'h7777;
        run_vec(v, 11);
        start_cycle(vecs[0]);
        ok = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            tick();
            if (mem_req) ok = 1'b1;
        end
        chk("rst_mid_req_seen", ok, 1'b1);
        @(negedge clk);
        _cpuReset = 1'b0;
        #1;
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_dtack", _cpuDTACK, 1'b1);
        chk("rst_mid_vpa", _cpuVPA, 1'b1);
        chk("rst_mid_data_in", cpuDataIn, 16'hFFFF);
        _cpuAS = 1'b1; _cpuUDS = 1'b1; _cpuLDS = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        _cpuReset = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_req || !_cpuDTACK) bad = 1'b1;
        end
        chk("rst_mid_after", bad, 1'b0);
        chk("rst_mid_data_after", cpuDataIn, 16'hFFFF);
        pulses = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
